// File: rtl/simple_if_pkg.sv
// Shared types and default sizing for the simple_if requester.
package simple_if_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} srm_state_t;

    localparam int unsigned SRM_ADDR_W = 8;
    localparam int unsigned SRM_DATA_W = 8;
    localparam int unsigned SRM_DEPTH  = 4;
    localparam int unsigned SRM_TMO_W  = 4;
    localparam int unsigned TMO_MAX    = (1 << SRM_TMO_W) - 1;

    typedef struct packed {
        logic [SRM_ADDR_W-1:0] addr;
        logic [SRM_DATA_W-1:0] data;
    } srm_cmd_t;

    // Number of REQ cycles before an unacknowledged request times out.
    function automatic int unsigned tmo_limit(input int unsigned w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/simple_cmd_fifo.sv
// Command FIFO: registered storage, combinational head, wrap-bit pointers.
module simple_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             full_nxt_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
        return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    assign wr_ptr_d   = wr_ptr_q + PW'(push_i);
    assign rd_ptr_d   = rd_ptr_q + PW'(pop_i);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = ptr_full(wr_ptr_q, rd_ptr_q);
    assign full_nxt_o = ptr_full(wr_ptr_d, rd_ptr_d);
    assign head_o     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/simple_req_master.sv
// simple_if requester: queues commands, issues them one at a time, and returns
// the acknowledged data (or a timeout error) on a single-entry response port.
module simple_req_master
    import simple_if_pkg::*;
#(
    parameter int unsigned ADDR_W = SRM_ADDR_W,
    parameter int unsigned DATA_W = SRM_DATA_W,
    parameter int unsigned DEPTH  = SRM_DEPTH,
    parameter int unsigned TMO_W  = SRM_TMO_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              req,
    input  logic              req_ack
);
    localparam int unsigned TMO_LIM = tmo_limit(TMO_W);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    srm_state_t        state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              cmd_ready_q;

    cmd_t fifo_wdata, fifo_head;
    logic fifo_full, fifo_empty, fifo_full_nxt;
    logic push, start, ack, tmo;

    assign fifo_wdata = '{addr: cmd_addr, data: cmd_data};
    assign push  = cmd_valid && cmd_ready_q && !fifo_full;
    // Launch only when the response slot is free or is being drained this cycle.
    assign start = (state_q == IDLE) && !fifo_empty && (!rsp_valid_q || rsp_ready);
    assign ack   = (state_q == REQ) && req_ack;
    assign tmo   = (state_q == REQ) && !req_ack && (cnt_q == TMO_W'(TMO_LIM - 1));

    simple_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (push),
        .pop_i      (start),
        .wdata_i    (fifo_wdata),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .full_nxt_o (fifo_full_nxt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)       state_d = REQ;
            REQ:     if (ack || tmo)  state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        req_d       = req_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (start) begin
            cnt_d   = '0;
            req_d   = 1'b1;
            addr_d  = fifo_head.addr;
            wdata_d = fifo_head.data;
        end
        if (state_q == REQ) begin
            cnt_d = cnt_q + TMO_W'(1);
            // An ack in the timeout cycle still counts as a normal completion.
            if (ack) begin
                req_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_out;
                rsp_err_d   = 1'b0;
            end else if (tmo) begin
                req_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= !fifo_full_nxt;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign req       = req_q;
    assign addr      = addr_q;
    assign data_in   = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_simple_req_master.sv
// Randomized bench for simple_req_master with a transaction-level reference model.
module tb_simple_req_master;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TMO_W   = 4;
    localparam int TMO_CYC = 15;
    localparam int NEVER   = 1000;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } tcmd_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_addr, cmd_data;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_data;
    logic [7:0] addr, data_in, data_out;
    logic       req, req_ack;

    always #5 clk = ~clk;

    simple_req_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TMO_W  (TMO_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .req       (req),
        .req_ack   (req_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: commands waiting, the one on the bus, and the response slot.
    tcmd_t      m_q[$];
    tcmd_t      dir_q[$];
    bit         m_req, m_rsp_v, m_rsp_e, m_ready;
    logic [7:0] m_addr, m_data, m_rsp_d;
    int         m_age, m_tgt;
    bit         cur_dir;

    int          knob_valid, knob_ready, knob_delay;
    bit          knob_fix_dout;
    logic [7:0]  knob_dout;

    int         hi_cnt, rise_cnt, hs_cnt;
    bit         prev_req, saw_busy;
    logic [7:0] last_d;
    logic       last_e;

    task automatic model_reset();
        m_q.delete();
        dir_q.delete();
        m_req = 0; m_rsp_v = 0; m_rsp_e = 0; m_ready = 0;
        m_addr = '0; m_data = '0; m_rsp_d = '0;
        m_age = 0; m_tgt = NEVER; cur_dir = 0;
    endtask

    function automatic int pick_delay();
        int r;
        if (knob_delay != 0) return knob_delay;
        r = int'($urandom_range(0, 9));
        if (r <= 5) return r + 1;
        if (r == 6) return 14;
        if (r == 7) return 15;
        if (r == 8) return 16;
        return NEVER;
    endfunction

    task automatic model_edge();
        bit    push, issue, consume, fin_ack, fin_tmo;
        tcmd_t c;
        push    = cmd_valid && m_ready;
        issue   = !m_req && (m_q.size() > 0) && (!m_rsp_v || rsp_ready);
        consume = m_rsp_v && rsp_ready;
        fin_ack = m_req && req_ack;
        fin_tmo = m_req && !req_ack && (m_age == TMO_CYC);
        if (consume) m_rsp_v = 0;
        if (fin_ack) begin
            m_rsp_v = 1; m_rsp_d = data_out; m_rsp_e = 0;
        end else if (fin_tmo) begin
            m_rsp_v = 1; m_rsp_d = '0; m_rsp_e = 1;
        end
        if (issue) begin
            c = m_q.pop_front();
            m_addr = c.addr; m_data = c.data;
            m_req = 1; m_age = 1; m_tgt = pick_delay();
        end else if (fin_ack || fin_tmo) begin
            m_req = 0;
        end else if (m_req) begin
            m_age++;
        end
        if (push) begin
            m_q.push_back('{addr: cmd_addr, data: cmd_data});
            if (cur_dir) void'(dir_q.pop_front());
        end
        m_ready = (m_q.size() < DEPTH);
    endtask

    task automatic compare();
        check("req",       32'(req),       32'(m_req));
        check("addr",      32'(addr),      32'(m_addr));
        check("data_in",   32'(data_in),   32'(m_data));
        check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
        check("rsp_data",  32'(rsp_data),  32'(m_rsp_d));
        check("rsp_err",   32'(rsp_err),   32'(m_rsp_e));
    endtask

    task automatic monitor();
        if (req === 1'b1) hi_cnt++;
        if (req === 1'b1 && !prev_req) rise_cnt++;
        prev_req = (req === 1'b1);
        if (cmd_ready === 1'b0) saw_busy = 1;
        if (rsp_valid === 1'b1) begin
            last_d = rsp_data;
            last_e = rsp_err;
            if (rsp_ready) hs_cnt++;
        end
    endtask

    task automatic drive();
        if (dir_q.size() > 0) begin
            cur_dir   = 1;
            cmd_valid = 1'b1;
            cmd_addr  = dir_q[0].addr;
            cmd_data  = dir_q[0].data;
        end else begin
            cur_dir   = 0;
            cmd_valid = (int'($urandom_range(0, 99)) < knob_valid);
            cmd_addr  = 8'($urandom);
            cmd_data  = 8'($urandom);
        end
        rsp_ready = (int'($urandom_range(0, 99)) < knob_ready);
        data_out  = knob_fix_dout ? knob_dout : 8'($urandom);
        if (m_req) req_ack = (m_age == m_tgt);
        else       req_ack = ($urandom_range(0, 7) == 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        monitor();
        drive();
    endtask

    task automatic clear_mon();
        hi_cnt = 0; rise_cnt = 0; hs_cnt = 0; saw_busy = 0;
        last_d = 'x; last_e = 'x;
    endtask

    task automatic run_until_idle(input string tag, input int limit);
        bit done;
        done = 0;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (dir_q.size() == 0 && m_q.size() == 0 && !m_req && !m_rsp_v) begin
                done = 1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic set_knobs(input int v, input int r, input int d);
        knob_valid = v; knob_ready = r; knob_delay = d;
    endtask

    initial begin
        bit reached;
        cmd_valid = 0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 0; data_out = '0; req_ack = 0;
        resetn = 1'b0;
        knob_fix_dout = 0; knob_dout = '0;
        set_knobs(0, 100, 2);
        model_reset();
        prev_req = 0;
        clear_mon();
        repeat (2) @(negedge clk);
        compare();
        resetn = 1'b1;

        // Single command, ack three cycles after req rises.
        clear_mon();
        set_knobs(0, 100, 4);
        knob_fix_dout = 1; knob_dout = 8'h5A;
        dir_q.push_back('{addr: 8'h3C, data: 8'hA5});
        run_until_idle("t1_idle", 40);
        check("t1_req_cycles", 32'(hi_cnt), 32'd4);
        check("t1_rsp_data",   32'(last_d), 32'h5A);
        check("t1_rsp_err",    32'(last_e), 32'd0);

        // Five back-to-back commands against a slow slave.
        clear_mon();
        knob_fix_dout = 0;
        set_knobs(0, 100, 10);
        for (int i = 0; i < 5; i++) dir_q.push_back('{addr: 8'(8'h10 + i), data: 8'(8'hC0 + i)});
        run_until_idle("t2_idle", 200);
        check("t2_backpressure", 32'(saw_busy), 32'd1);
        check("t2_responses",    32'(hs_cnt),   32'd5);

        // Slave never answers: timeout error.
        clear_mon();
        set_knobs(0, 100, NEVER);
        dir_q.push_back('{addr: 8'h77, data: 8'h11});
        run_until_idle("t3_idle", 60);
        check("t3_req_cycles", 32'(hi_cnt), 32'd15);
        check("t3_rsp_err",    32'(last_e), 32'd1);
        check("t3_rsp_data",   32'(last_d), 32'd0);

        // Ack on exactly the last allowed cycle wins over the timeout.
        clear_mon();
        set_knobs(0, 100, 15);
        knob_fix_dout = 1; knob_dout = 8'hC3;
        dir_q.push_back('{addr: 8'h42, data: 8'h24});
        run_until_idle("t4_idle", 60);
        check("t4_req_cycles", 32'(hi_cnt), 32'd15);
        check("t4_rsp_err",    32'(last_e), 32'd0);
        check("t4_rsp_data",   32'(last_d), 32'hC3);
        knob_fix_dout = 0;

        // Response held unread: no second request until it is taken.
        clear_mon();
        set_knobs(0, 0, 2);
        dir_q.push_back('{addr: 8'h01, data: 8'h02});
        dir_q.push_back('{addr: 8'h03, data: 8'h04});
        repeat (10) cycle();
        check("t5_held_rises", 32'(rise_cnt), 32'd1);
        knob_ready = 100;
        run_until_idle("t5_idle", 60);
        check("t5_total_rises", 32'(rise_cnt), 32'd2);

        // Asynchronous reset in REQ with three commands queued.
        set_knobs(0, 0, NEVER);
        for (int i = 0; i < 4; i++) dir_q.push_back('{addr: 8'(8'hE0 + i), data: 8'(8'h50 + i)});
        reached = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (m_req && m_q.size() == 3) begin
                reached = 1;
                break;
            end
        end
        check("t6_reach", 32'(reached), 32'd1);
        check("t6_req_before", 32'(req), 32'd1);
        #2 resetn = 1'b0;
        model_reset();
        #1 compare();
        @(negedge clk);
        compare();
        cmd_valid = 0; rsp_ready = 0; req_ack = 0;
        resetn = 1'b1;
        set_knobs(0, 100, 3);
        repeat (6) cycle();
        clear_mon();
        dir_q.push_back('{addr: 8'h99, data: 8'h66});
        run_until_idle("t6_idle", 40);
        check("t6_after_rises", 32'(rise_cnt), 32'd1);

        // Random traffic with mixed slave delays, spurious acks and back-pressure.
        set_knobs(40, 60, 0);
        repeat (800) cycle();
        set_knobs(0, 100, 0);
        run_until_idle("rand_drain", 400);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
